// File: rtl/mem_cycle_ctrl_pkg.sv
// Shared encodings for the MAR/MDR memory cycle sequencer.
// State codes are 4-bit so the table can grow without touching port widths.
package mem_ctrl_pkg;

  localparam int DEF_TIMEOUT = 15;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR_RD  = 4'd1;
  localparam logic [3:0] ST_ADDR_WR  = 4'd2;
  localparam logic [3:0] ST_RD_WAIT  = 4'd3;
  localparam logic [3:0] ST_RD_LATCH = 4'd4;
  localparam logic [3:0] ST_RD_DRIVE = 4'd5;
  localparam logic [3:0] ST_WR_WAIT  = 4'd6;
  localparam logic [3:0] ST_WR_DONE  = 4'd7;
  localparam logic [3:0] ST_ERR      = 4'd8;

  typedef struct packed {
    logic mar_load;
    logic mem_rd;
    logic mem_wr;
    logic mdr_from_mem;
    logic mdr_to_bus;
    logic busy;
    logic done;
    logic err_timeout;
  } cycle_out_t;

  function automatic logic is_wait_state(input logic [3:0] st);
    return (st == ST_RD_WAIT) || (st == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/mem_cycle_ctrl_if.sv
// Request / memory / MDR control bundle between the control unit, memory and MDR.
// The sequencer takes the slave side; the requester and memory model take master.
interface mem_cycle_if #(
  parameter int ADDR_W = 16
);

  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_ready;

  logic [ADDR_W-1:0] mar_addr;
  logic              MAR_load;
  logic              mem_rd;
  logic              mem_wr;
  logic              MDR_from_MEM_En;
  logic              MDR_Data_toBus_TRI_En;
  logic              busy;
  logic              done;
  logic              err_timeout;

  modport slave (
    input  req_rd, req_wr, req_addr, mem_ready,
    output mar_addr, MAR_load, mem_rd, mem_wr, MDR_from_MEM_En,
           MDR_Data_toBus_TRI_En, busy, done, err_timeout
  );

  modport master (
    output req_rd, req_wr, req_addr, mem_ready,
    input  mar_addr, MAR_load, mem_rd, mem_wr, MDR_from_MEM_En,
           MDR_Data_toBus_TRI_En, busy, done, err_timeout
  );

endinterface

// File: rtl/mem_cycle_ctrl_timer.sv
// Wait-state down-counter: loads TIMEOUT, counts toward zero, flags expiry at zero.
// It never wraps, so a stray decrement at zero leaves it expired.
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Sequences one MAR/MDR memory read or write with a ready handshake and timeout abort.
// All outputs decode from registered state, so nothing flows combinationally in to out.
//
// state    | meaning
// IDLE     | waiting for req_rd / req_wr, captures address on accept
// ADDR_RD  | MAR_load for a read, arms timer
// ADDR_WR  | MAR_load for a write, arms timer
// RD_WAIT  | mem_rd held, waiting on mem_ready
// RD_LATCH | mem_rd + MDR latches memory data
// RD_DRIVE | MDR drives bus, done pulse
// WR_WAIT  | mem_wr held, waiting on mem_ready
// WR_DONE  | done pulse
// ERR      | err_timeout pulse, strobes dropped
module mem_cycle_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic       clk,
  input logic       rst,
  mem_cycle_if.slave bus
);

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [ADDR_W-1:0] r_mar_addr;
  cycle_out_t        w_out;
  logic              w_tmr_load;
  logic              w_tmr_dec;
  logic              w_expired;
  logic              w_accept;

  assign w_accept   = (r_state == ST_IDLE) && (bus.req_rd || bus.req_wr);
  assign w_tmr_load = (r_state == ST_ADDR_RD) || (r_state == ST_ADDR_WR);
  assign w_tmr_dec  = is_wait_state(r_state) && !bus.mem_ready;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmr_load),
    .i_dec     (w_tmr_dec),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mar_addr <= '0;
    end else if (w_accept) begin
      r_mar_addr <= bus.req_addr;
    end
  end

  // mem_ready is checked before expiry so a late ready still completes
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_rd)      w_next = ST_ADDR_RD;
        else if (bus.req_wr) w_next = ST_ADDR_WR;
      end
      ST_ADDR_RD:  w_next = ST_RD_WAIT;
      ST_ADDR_WR:  w_next = ST_WR_WAIT;
      ST_RD_WAIT: begin
        if (bus.mem_ready)   w_next = ST_RD_LATCH;
        else if (w_expired)  w_next = ST_ERR;
      end
      ST_RD_LATCH: w_next = ST_RD_DRIVE;
      ST_RD_DRIVE: w_next = ST_IDLE;
      ST_WR_WAIT: begin
        if (bus.mem_ready)   w_next = ST_WR_DONE;
        else if (w_expired)  w_next = ST_ERR;
      end
      ST_WR_DONE:  w_next = ST_IDLE;
      ST_ERR:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_out      = '0;
    w_out.busy = (r_state != ST_IDLE);
    case (r_state)
      ST_ADDR_RD,
      ST_ADDR_WR:  w_out.mar_load = 1'b1;
      ST_RD_WAIT:  w_out.mem_rd = 1'b1;
      ST_RD_LATCH: begin
        w_out.mem_rd       = 1'b1;
        w_out.mdr_from_mem = 1'b1;
      end
      ST_RD_DRIVE: begin
        w_out.mdr_to_bus = 1'b1;
        w_out.done       = 1'b1;
      end
      ST_WR_WAIT:  w_out.mem_wr = 1'b1;
      ST_WR_DONE:  w_out.done = 1'b1;
      ST_ERR:      w_out.err_timeout = 1'b1;
      default:     w_out.busy = 1'b0;
    endcase
  end

  assign bus.mar_addr              = r_mar_addr;
  assign bus.MAR_load              = w_out.mar_load;
  assign bus.mem_rd                = w_out.mem_rd;
  assign bus.mem_wr                = w_out.mem_wr;
  assign bus.MDR_from_MEM_En       = w_out.mdr_from_mem;
  assign bus.MDR_Data_toBus_TRI_En = w_out.mdr_to_bus;
  assign bus.busy                  = w_out.busy;
  assign bus.done                  = w_out.done;
  assign bus.err_timeout           = w_out.err_timeout;

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Randomized bench for mem_cycle_ctrl: each transaction's expected per-cycle
// output trace is built from the cycle rules (phase lengths), then compared cycle by cycle.
module tb_mem_cycle_ctrl;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  // expected-vector bit order
  localparam logic [7:0] E_MARLD = 8'b1000_0000;
  localparam logic [7:0] E_RD    = 8'b0100_0000;
  localparam logic [7:0] E_WR    = 8'b0010_0000;
  localparam logic [7:0] E_FROM  = 8'b0001_0000;
  localparam logic [7:0] E_TRI   = 8'b0000_1000;
  localparam logic [7:0] E_BUSY  = 8'b0000_0100;
  localparam logic [7:0] E_DONE  = 8'b0000_0010;
  localparam logic [7:0] E_ERR   = 8'b0000_0001;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_cycle_if #(.ADDR_W(ADDR_W)) bus_if ();

  mem_cycle_ctrl #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] obs_vec();
    return {bus_if.MAR_load, bus_if.mem_rd, bus_if.mem_wr, bus_if.MDR_from_MEM_En,
            bus_if.MDR_Data_toBus_TRI_En, bus_if.busy, bus_if.done, bus_if.err_timeout};
  endfunction

  // Entered and left at a negedge with the DUT idle. d = wait cycles with mem_ready
  // low before it rises; d > TIMEOUT means it never rises in time.
  task automatic run_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                         input int d, input bit noise);
    logic [7:0] exp_q[$];
    bit         is_rd;
    bit         tmo;
    int         nwait;
    is_rd = rd;
    tmo   = (d > TIMEOUT);
    nwait = tmo ? TIMEOUT + 1 : d + 1;
    exp_q.push_back(E_MARLD | E_BUSY);
    for (int k = 0; k < nwait; k++) exp_q.push_back((is_rd ? E_RD : E_WR) | E_BUSY);
    if (tmo)        exp_q.push_back(E_ERR | E_BUSY);
    else if (is_rd) begin
      exp_q.push_back(E_RD | E_FROM | E_BUSY);
      exp_q.push_back(E_TRI | E_DONE | E_BUSY);
    end else        exp_q.push_back(E_DONE | E_BUSY);

    check_val("idle_pre", {24'd0, obs_vec()}, 32'd0);
    bus_if.req_rd    = rd;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    bus_if.mem_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_val(is_rd ? "rd_cycle" : "wr_cycle", {24'd0, obs_vec()}, {24'd0, exp_q[i]});
      check_val("mar_addr", {16'd0, bus_if.mar_addr}, {16'd0, addr});
      if (i >= 1 && i <= nwait) bus_if.mem_ready = ((i - 1) >= d);
      else                      bus_if.mem_ready = 1'($urandom_range(0, 1));
      if (noise) begin
        bus_if.req_addr = ADDR_W'($urandom);
        if (is_rd) bus_if.req_wr = 1'($urandom_range(0, 1));
        else       bus_if.req_rd = 1'($urandom_range(0, 1));
      end
      if (i == exp_q.size() - 1) begin
        bus_if.req_rd = 1'b0;
        bus_if.req_wr = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit               rd;
    bit               wr;
    int               d;
    logic [ADDR_W-1:0] a;
    n_tests = 0;
    n_fail  = 0;
    rst              = 1'b0;
    bus_if.req_rd    = 1'b1;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 16'hABCD;
    bus_if.mem_ready = 1'b1;

    // reset held with a pending read
    repeat (2) begin
      @(negedge clk);
      check_val("rst_outs", {24'd0, obs_vec()}, 32'd0);
      check_val("rst_mar", {16'd0, bus_if.mar_addr}, 32'd0);
    end
    rst = 1'b1;
    run_txn(1'b1, 1'b0, 16'hABCD, 0, 1'b0);

    run_txn(1'b1, 1'b0, 16'h1234, 0, 1'b0);
    run_txn(1'b0, 1'b1, 16'h00FF, 3, 1'b0);
    run_txn(1'b1, 1'b0, 16'h5A5A, 1000, 1'b0);
    run_txn(1'b0, 1'b1, 16'hA5A5, TIMEOUT + 1, 1'b1);
    run_txn(1'b1, 1'b1, 16'h0042, TIMEOUT, 1'b1);
    run_txn(1'b0, 1'b1, 16'h0F0F, TIMEOUT, 1'b1);

    // reset in the middle of a read wait
    bus_if.req_rd    = 1'b1;
    bus_if.req_addr  = 16'hBEEF;
    bus_if.mem_ready = 1'b0;
    @(negedge clk);
    check_val("r6_marld", {24'd0, obs_vec()}, {24'd0, E_MARLD | E_BUSY});
    repeat (2) begin
      @(negedge clk);
      check_val("r6_wait", {24'd0, obs_vec()}, {24'd0, E_RD | E_BUSY});
    end
    rst = 1'b0;
    @(negedge clk);
    check_val("r6_rst_outs", {24'd0, obs_vec()}, 32'd0);
    check_val("r6_rst_mar", {16'd0, bus_if.mar_addr}, 32'd0);
    bus_if.req_rd    = 1'b0;
    bus_if.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val("r6_quiet", {24'd0, obs_vec()}, 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = ADDR_W'($urandom);
      d  = ($urandom_range(0, 5) == 0) ? TIMEOUT + 1 + $urandom_range(0, 3)
                                       : $urandom_range(0, TIMEOUT);
      run_txn(rd, wr, a, d, 1'($urandom_range(0, 1)));
    end

    check_val("idle_end", {24'd0, obs_vec()}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
